// File: rtl/vga_timing_gen_if.sv
// Pixel-source link between the raster engine (master) and the frame-buffer/game logic (slave).
// Carries the per-pixel request with its coordinates and the frame strobe out, and the colour back.
// No backpressure: the source must answer every request within the pixel period.
interface vga_timing_gen_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int COLOR_W = 4
);
  logic                   pix_req;
  logic [X_W-1:0]         pix_x;
  logic [Y_W-1:0]         pix_y;
  logic                   frame_start;
  logic [3*COLOR_W-1:0]   pix_data;

  modport master (
    output pix_req,
    output pix_x,
    output pix_y,
    output frame_start,
    input  pix_data
  );

  modport slave (
    input  pix_req,
    input  pix_x,
    input  pix_y,
    input  frame_start,
    output pix_data
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: sync, blanking, pixel coordinates and registered RGB.
// Latency: hs/vs/r/g/b lag pix_x/pix_y by one pixel period (CLK_DIV clks).
// No backpressure: one request per pixel period. Optional border overlay via VGA_BORDER_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter int COLOR_W  = 4,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  vga_timing_gen_if.master   pix,
  output logic               hs,
  output logic               vs,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int RGB_W   = 3 * COLOR_W;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
  localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);

  // Compared one bit wider so a zero back porch cannot overflow the sync end bound.
  localparam logic [X_W:0] H_ACT    = (X_W+1)'(H_ACTIVE);
  localparam logic [X_W:0] HS_START = (X_W+1)'(H_ACTIVE + H_FP);
  localparam logic [X_W:0] HS_END   = (X_W+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W:0] V_ACT    = (Y_W+1)'(V_ACTIVE);
  localparam logic [Y_W:0] VS_START = (Y_W+1)'(V_ACTIVE + V_FP);
  localparam logic [Y_W:0] VS_END   = (Y_W+1)'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic             ce;
  logic [X_W-1:0]   h;
  logic [Y_W-1:0]   v;
  logic             de0;
  logic             hs0;
  logic             vs0;
  logic [RGB_W-1:0] rgb_nxt;
  logic [RGB_W-1:0] rgb_q;

  // Pixel-clock enable: last clk of each pixel period.
  assign ce = (div == DIV_LAST);

  // Prescaler counting clk cycles within one pixel period.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div <= '0;
    end else if (ce) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  // Raster counters: h steps per pixel, v steps when h wraps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      h <= '0;
      v <= '0;
    end else if (ce) begin
      if (h == H_LAST) begin
        h <= '0;
        if (v == V_LAST) begin
          v <= '0;
        end else begin
          v <= v + 1'b1;
        end
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // Stage 0: display enable, raw sync windows and the colour to load at the period end.
  always_comb begin
    de0 = ({1'b0, h} < H_ACT) && ({1'b0, v} < V_ACT);
    hs0 = ({1'b0, h} >= HS_START) && ({1'b0, h} < HS_END);
    vs0 = ({1'b0, v} >= VS_START) && ({1'b0, v} < VS_END);
    rgb_nxt = '0;
`ifdef VGA_BORDER_EN
    if (de0) begin
      if ((h == '0) || (h == X_W'(H_ACTIVE - 1)) || (v == '0) || (v == Y_W'(V_ACTIVE - 1))) begin
        rgb_nxt = '1;
      end else begin
        rgb_nxt = pix.pix_data;
      end
    end
`else
    if (de0) begin
      rgb_nxt = pix.pix_data;
    end
`endif
  end

  // Stage 1: sync and colour registered together on ce so all five stay aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs    <= ~HS_POL;
      vs    <= ~VS_POL;
      rgb_q <= '0;
    end else if (ce) begin
      hs    <= hs0 ? HS_POL : ~HS_POL;
      vs    <= vs0 ? VS_POL : ~VS_POL;
      rgb_q <= rgb_nxt;
    end
  end

  assign {r, g, b}       = rgb_q;
  assign pix.pix_req     = de0;
  assign pix.pix_x       = h;
  assign pix.pix_y       = v;
  assign pix.frame_start = (h == '0) && (v == '0) && (div == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a tiny 8x6 raster with CLK_DIV=2 (96 clks per frame).
// Expected sync/colour per pixel is queued when the pixel period is driven and popped at its ce edge.
// Works for both the default build and the VGA_BORDER_EN build.
module tb_vga_timing_gen;
  localparam int CLK_DIV    = 2;
  localparam int H_TOTAL    = 8;
  localparam int V_TOTAL    = 6;
  localparam int FRAME_CLKS = 96;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hs, vs;
  logic [3:0] r, g, b;

  vga_timing_gen_if #(.X_W(3), .Y_W(3), .COLOR_W(4)) pix ();

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .CLK_DIV(CLK_DIV), .COLOR_W(4), .HS_POL(1'b0), .VS_POL(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pix(pix),
    .hs(hs), .vs(vs), .r(r), .g(g), .b(b)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t held;
  logic fresh;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_div, m_h, m_v;
  int   last_fs, fs_seen, hs_falls, vs_falls, hs_run, vs_run, x5_cyc, nz;
  bit   have_fs;
  logic prev_fs, prev_hs, prev_vs;
  logic [2:0] prev_x;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic reset_model();
    m_div = 0; m_h = 0; m_v = 0;
    held = '{hs: 1'b1, vs: 1'b1, rgb: 12'h000};
    sb.delete();
    fresh = 1'b0;
    have_fs = 1'b0;
    prev_fs = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1; prev_x = 3'd0;
    hs_run = 0; vs_run = 0; x5_cyc = -100;
  endtask

  // One clk: check the current sample, queue the pixel's expected output, drive data, advance.
  // mode 0: tagged {x,y,A}; 1: all ones; 2: zero
  task automatic step(input int mode);
    logic [11:0] d;
    logic        de_m, fs_m, bd;
    exp_t        e;
    de_m = (m_h < 4) && (m_v < 3);
    fs_m = (m_h == 0) && (m_v == 0) && (m_div == 0);
    bd = 1'b0;
`ifdef VGA_BORDER_EN
    bd = (m_h == 0) || (m_h == 3) || (m_v == 0) || (m_v == 2);
`endif
    checks++;
    if ({pix.pix_x, pix.pix_y} !== {3'(m_h), 3'(m_v)}) begin
      errors++;
      $display("FAIL coord cyc=%0d got x=%0d y=%0d want x=%0d y=%0d", cyc, pix.pix_x, pix.pix_y, m_h, m_v);
    end
    checks++;
    if ({pix.pix_req, pix.frame_start} !== {de_m, fs_m}) begin
      errors++;
      $display("FAIL req_fs cyc=%0d got req=%b fs=%b want req=%b fs=%b", cyc, pix.pix_req, pix.frame_start, de_m, fs_m);
    end
    checks++;
    if ({hs, vs, r, g, b} !== held) begin
      errors++;
      $display("FAIL video cyc=%0d got hs=%b vs=%b rgb=%h want hs=%b vs=%b rgb=%h", cyc, hs, vs, {r, g, b}, held.hs, held.vs, held.rgb);
    end
    if (pix.frame_start === 1'b1) begin
      fs_seen++;
      checks++;
      if (prev_fs === 1'b1) begin
        errors++;
        $display("FAIL fs_width cyc=%0d got width>1 want 1", cyc);
      end
      if (have_fs) begin
        checks++;
        if (cyc - last_fs != FRAME_CLKS) begin
          errors++;
          $display("FAIL fs_period cyc=%0d got %0d want %0d", cyc, cyc - last_fs, FRAME_CLKS);
        end
      end
      have_fs = 1'b1;
      last_fs = cyc;
    end
    if (pix.pix_x == 3'd5 && prev_x != 3'd5) x5_cyc = cyc;
    if (hs === 1'b0) begin
      if (prev_hs === 1'b1) begin
        hs_falls++;
        checks++;
        if (cyc - x5_cyc != 2) begin
          errors++;
          $display("FAIL hs_start cyc=%0d got %0d clks after x=5 want 2", cyc, cyc - x5_cyc);
        end
      end
      hs_run++;
    end else if (hs_run > 0) begin
      checks++;
      if (hs_run != 4) begin
        errors++;
        $display("FAIL hs_width cyc=%0d got %0d want 4", cyc, hs_run);
      end
      hs_run = 0;
    end
    if (vs === 1'b0) begin
      if (prev_vs === 1'b1) vs_falls++;
      vs_run++;
    end else if (vs_run > 0) begin
      checks++;
      if (vs_run != 16) begin
        errors++;
        $display("FAIL vs_width cyc=%0d got %0d want 16", cyc, vs_run);
      end
      vs_run = 0;
    end
    if (fresh && ({r, g, b} != 12'h000)) nz++;
    fresh = 1'b0;
    prev_fs = pix.frame_start; prev_hs = hs; prev_vs = vs; prev_x = pix.pix_x;

    case (mode)
      0:       d = {1'b0, 3'(m_h), 1'b0, 3'(m_v), 4'hA};
      1:       d = 12'hFFF;
      default: d = 12'h000;
    endcase
    if (m_div == CLK_DIV - 1) begin
      e.hs  = (m_h >= 5 && m_h < 7) ? 1'b0 : 1'b1;
      e.vs  = (m_v == 4) ? 1'b0 : 1'b1;
      e.rgb = !de_m ? 12'h000 : (bd ? 12'hFFF : d);
      sb.push_back(e);
    end
    pix.pix_data = d;

    tick();
    if (m_div == CLK_DIV - 1) begin
      m_div = 0;
      if (m_h == H_TOTAL - 1) begin
        m_h = 0;
        m_v = (m_v == V_TOTAL - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end else begin
      m_div++;
    end
    if (sb.size() > 0) begin
      held = sb.pop_front();
      fresh = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pix.pix_data = 12'hFFF;
    repeat (5) tick();
    checks++;
    if ({hs, vs} !== 2'b11) begin
      errors++;
      $display("FAIL reset_sync got hs=%b vs=%b want 1 1", hs, vs);
    end
    checks++;
    if ({r, g, b} !== 12'h000) begin
      errors++;
      $display("FAIL reset_rgb got %h want 000", {r, g, b});
    end
    rst_n = 1'b1;
    reset_model();
    checks++;
    if ({pix.frame_start, pix.pix_x, pix.pix_y} !== 7'b1_000_000) begin
      errors++;
      $display("FAIL release_fs got fs=%b x=%0d y=%0d want 1 0 0", pix.frame_start, pix.pix_x, pix.pix_y);
    end
  endtask

  task automatic test_frame_period();
    fs_seen = 0;
    for (int i = 0; i < 3 * FRAME_CLKS; i++) step(0);
    checks++;
    if (fs_seen != 3) begin
      errors++;
      $display("FAIL fs_count got %0d want 3", fs_seen);
    end
  endtask

  task automatic test_sync_shape();
    hs_falls = 0;
    vs_falls = 0;
    for (int i = 0; i < FRAME_CLKS; i++) step(0);
    checks++;
    if (hs_falls != 6 || vs_falls != 1) begin
      errors++;
      $display("FAIL sync_count got hs=%0d vs=%0d want hs=6 vs=1", hs_falls, vs_falls);
    end
  endtask

  task automatic test_data_path();
    int want;
    for (int mode = 0; mode < 3; mode++) begin
      nz = 0;
      for (int i = 0; i < FRAME_CLKS; i++) step(mode);
      want = (mode == 2) ? 0 : 12;
`ifdef VGA_BORDER_EN
      if (mode == 2) want = 10;
`endif
      checks++;
      if (nz != want) begin
        errors++;
        $display("FAIL lit_pixels mode=%0d got %0d want %0d", mode, nz, want);
      end
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    while (!(m_h == 2 && m_v == 1 && m_div == 0) && n < 200) begin
      step(0);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL mid_reset_reach got no (2,1) within 200 clks want reached");
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if ({hs, vs, r, g, b} !== {2'b11, 12'h000}) begin
      errors++;
      $display("FAIL mid_reset_out got hs=%b vs=%b rgb=%h want 1 1 000", hs, vs, {r, g, b});
    end
    checks++;
    if ({pix.pix_x, pix.pix_y} !== 6'd0) begin
      errors++;
      $display("FAIL mid_reset_coord got x=%0d y=%0d want 0 0", pix.pix_x, pix.pix_y);
    end
    rst_n = 1'b1;
    reset_model();
    checks++;
    if (pix.frame_start !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_fs got %b want 1", pix.frame_start);
    end
    step(0);
    checks++;
    if (pix.frame_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_fs_width got %b want 0", pix.frame_start);
    end
    fs_seen = 0;
    for (int i = 0; i < FRAME_CLKS + 4; i++) step(0);
    checks++;
    if (fs_seen != 1) begin
      errors++;
      $display("FAIL mid_reset_next_frame got %0d want 1", fs_seen);
    end
  endtask

  initial begin
    pix.pix_data = 12'h000;
    test_reset();
    test_frame_period();
    test_sync_shape();
    test_data_path();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster engine that generates sync, blanking and pixel coordinates and returns registered RGB from a pixel source. It succeeds the fixed 640x480 display path in TOP. Resolution, porches, sync polarity, clock prescale and colour depth are parameters. It adds a pixel-request handshake, a frame-start strobe and an optional border overlay. It sits between the frame-buffer/game logic and the r/g/b/hs/vs board pins.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch / sync / back porch (lines)
- CLK_DIV, 4, clk cycles per pixel (>=1; 4 gives 25 MHz from 100 MHz)
- COLOR_W, 4, bits per colour channel
- HS_POL / VS_POL, 0 / 0, sync active level (0 = active-low)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- pix_data  in  3*COLOR_W  {r,g,b} for the requested pixel
- pix_req  out  1  current pixel is in the active area; pix_x/pix_y valid
- pix_x  out  $clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)  horizontal counter
- pix_y  out  $clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)  vertical counter
- frame_start  out  1  one-clk strobe at the start of pixel (0,0)
- hs, vs  out  1  sync outputs
- r, g, b  out  COLOR_W  colour outputs, zero during blanking

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
- **Prescaler div**
  - Counts 0..CLK_DIV-1 and wraps.
  - ce = (div == CLK_DIV-1). With CLK_DIV=1, ce is always 1.
- **Raster counters h, v** (exported as pix_x, pix_y)
  - On ce, h increments.
  - When h == H_TOTAL-1, h wraps to 0 and v increments.
  - When v == V_TOTAL-1 at the same wrap, v wraps to 0.
- **Stage 0 (combinational from counters)**
  - de0 = (h < H_ACTIVE) && (v < V_ACTIVE).
  - hs0 is active when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
  - vs0 is active when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
  - pix_req = de0.
- **Stage 1 (registered on ce)**
  - hs <= hs0 ? HS_POL : ~HS_POL; vs is formed the same way with VS_POL.
  - {r,g,b} <= de0 ? pix_data : 0.
- frame_start = (h==0 && v==0 && div==0).
- The source sees one pixel request per pixel period. There is no backpressure and no stall.

## Timing
- **Reset values** (the clock edge with rst_n=0): div=h=v=0; hs=~HS_POL; vs=~VS_POL; r=g=b=0.
- The first clk after rst_n rises has frame_start=1.
- **pix_data setup:** pix_data must be valid at the clk edge where ce=1 that ends the pixel period. Earlier cycles in the period are don't-care.
- **Latency:** hs, vs, r, g, b lag pix_x/pix_y by exactly one pixel period (CLK_DIV clks). All five change only on ce edges, so they stay mutually aligned.
- **Line/frame wrap:** the last pixel of a line or frame is output one period after the counters wrap. The first active pixel's RGB follows the (0,0) request by one period.
- **Mid-frame reset:** counters, pipeline and outputs return to the reset values on that edge. No partial pixel is emitted. The next frame restarts at (0,0) with frame_start.
- **Blanking:** rgb is forced to 0 whenever de0 was 0, regardless of pix_data.

## Configuration
- VGA_BORDER_EN
  - Defined: when de0 and (h==0 || h==H_ACTIVE-1 || v==0 || v==V_ACTIVE-1), stage 1 loads all-ones RGB instead of pix_data. pix_req still asserts for these pixels.
  - Undefined: no overlay; RGB is always pix_data in the active area.

## Test plan
Small params for all cases: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), CLK_DIV=2, COLOR_W=4, polarity 0. This gives 96 clks per frame.
- **Reset:** hold rst_n=0 for 5 clks -> hs=vs=1, rgb=0. On the first clk after release, frame_start=1 and pix_x=pix_y=0.
- **Frame period:** run 3 frames -> frame_start pulses exactly 96 clks apart, 1 clk wide.
- **Sync shape:** hs low for exactly 4 clks per 16-clk line, starting 2 clks after pix_x reaches 5. vs low for exactly 1 line (16 clks) per frame.
- **Data path:** drive pix_data = {pix_x, pix_y, 4'hA} -> r/g/b = 4'hA-tagged values appear 2 clks after the request. 12 active pixels per frame; rgb is 0 elsewhere even with pix_data=12'hFFF.
- **Mid-frame reset:** assert rst_n=0 for 1 clk at pix_x=2, pix_y=1 -> outputs return to reset values on the next edge, and the next frame_start comes 1 clk after release.
- **VGA_BORDER_EN build:** pix_data=0 -> rgb=12'hFFF on all 10 edge pixels of the 4x3 area, and 0 on the 2 interior pixels.
